// File: rtl/me_best_mv_tracker.sv
// Best-MV tracker: keeps the minimum-cost candidate per coding sub-block over one search window
// and drains four records on frame_done. Optional MV cost term is enabled by ME_MV_COST_EN.
module me_best_mv_tracker #(
  parameter int unsigned SAD_W        = 16,
  parameter int unsigned ROW_OFFSET   = 32,
  parameter int unsigned COL_OFFSET   = 16,
  parameter int unsigned LAMBDA_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             frame_done,
  input  logic             sad_valid,
  input  logic [1:0]       sad_cb_id,
  input  logic [SAD_W-1:0] sad_value,
  input  logic [6:0]       search_row_count,
  input  logic [4:0]       search_column_count,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_cb_id,
  output logic [SAD_W-1:0] out_cost,
  output logic [7:0]       out_mv_x,
  output logic [7:0]       out_mv_y,
  output logic             out_last
);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

  if (LAMBDA_SHIFT > 15) begin : g_lambda_check
    $error("LAMBDA_SHIFT out of range");
  end

  state_t           state, state_nxt;
  logic             flush_cnt;
  logic [1:0]       rd_idx;
  logic             accept;
  logic             handshake;

  logic [SAD_W-1:0] tbl_cost [4];
  logic [7:0]       tbl_mv_x [4];
  logic [7:0]       tbl_mv_y [4];

  logic             s1_valid;
  logic [1:0]       s1_cb;
  logic [SAD_W-1:0] s1_cost;
  logic [7:0]       s1_mv_x;
  logic [7:0]       s1_mv_y;

  logic [7:0]       mv_x_c;
  logic [7:0]       mv_y_c;
  logic [SAD_W-1:0] cost_c;

  assign accept    = sad_valid && (state == ACCUM) && !frame_start;
  assign handshake = (state == DRAIN) && out_ready;
  assign mv_x_c    = {3'b000, search_column_count} - 8'(COL_OFFSET);
  assign mv_y_c    = {1'b0, search_row_count} - 8'(ROW_OFFSET);

`ifdef ME_MV_COST_EN
  localparam int unsigned WIDE_W = SAD_W + LAMBDA_SHIFT + 10;

  function automatic logic [7:0] mag8(input logic [7:0] v);
    return v[7] ? 8'(-v) : v;
  endfunction

  logic [8:0]        mv_mag;
  logic [WIDE_W-1:0] cost_wide;

  always_comb begin
    mv_mag    = {1'b0, mag8(mv_x_c)} + {1'b0, mag8(mv_y_c)};
    cost_wide = WIDE_W'(sad_value) + (WIDE_W'(mv_mag) << LAMBDA_SHIFT);
    cost_c    = (|cost_wide[WIDE_W-1:SAD_W]) ? '1 : cost_wide[SAD_W-1:0];
  end
`else
  assign cost_c = sad_value;
`endif

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        ACCUM:   if (frame_done) state_nxt = FLUSH;
        FLUSH:   if (flush_cnt) state_nxt = DRAIN;
        DRAIN:   if (handshake && rd_idx == 2'd3) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
      rd_idx    <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == FLUSH) && !frame_start && !flush_cnt;
      if (frame_start || state != DRAIN) rd_idx <= '0;
      else if (handshake)                rd_idx <= rd_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cb    <= '0;
      s1_cost  <= '0;
      s1_mv_x  <= '0;
      s1_mv_y  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_cb   <= sad_cb_id;
        s1_cost <= cost_c;
        s1_mv_x <= mv_x_c;
        s1_mv_y <= mv_y_c;
      end
    end
  end

  // S2 reads the table entry written on the previous edge, so back-to-back hits on one CB need no bypass mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        tbl_cost[i] <= '1;
        tbl_mv_x[i] <= '0;
        tbl_mv_y[i] <= '0;
      end
    end else if (frame_start) begin
      for (int unsigned i = 0; i < 4; i++) begin
        tbl_cost[i] <= '1;
        tbl_mv_x[i] <= '0;
        tbl_mv_y[i] <= '0;
      end
    end else if (s1_valid && s1_cost < tbl_cost[s1_cb]) begin
      tbl_cost[s1_cb] <= s1_cost;
      tbl_mv_x[s1_cb] <= s1_mv_x;
      tbl_mv_y[s1_cb] <= s1_mv_y;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_cb_id = '0;
    out_cost  = '0;
    out_mv_x  = '0;
    out_mv_y  = '0;
    if (state == DRAIN) begin
      out_valid = 1'b1;
      out_last  = (rd_idx == 2'd3);
      out_cb_id = rd_idx;
      out_cost  = tbl_cost[rd_idx];
      out_mv_x  = tbl_mv_x[rd_idx];
      out_mv_y  = tbl_mv_y[rd_idx];
    end
  end

endmodule

// File: tb/tb_me_best_mv_tracker.sv
// Self-checking bench for me_best_mv_tracker: per-cycle comparison against a behavioural
// minimum-per-CB model, plus directed scenarios with literal expectations.
module tb_me_best_mv_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_done = 1'b0;
  logic        sad_valid = 1'b0;
  logic [1:0]  sad_cb_id = '0;
  logic [15:0] sad_value = '0;
  logic [6:0]  search_row_count = '0;
  logic [4:0]  search_column_count = '0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_cb_id;
  logic [15:0] out_cost;
  logic [7:0]  out_mv_x;
  logic [7:0]  out_mv_y;
  logic        out_last;

  me_best_mv_tracker #(
    .SAD_W(16), .ROW_OFFSET(32), .COL_OFFSET(16), .LAMBDA_SHIFT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_done(frame_done),
    .sad_valid(sad_valid), .sad_cb_id(sad_cb_id), .sad_value(sad_value),
    .search_row_count(search_row_count), .search_column_count(search_column_count),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_cb_id(out_cb_id),
    .out_cost(out_cost), .out_mv_x(out_mv_x), .out_mv_y(out_mv_y), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, $signed(got), got,
               $signed(exp), exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 accumulate, 2/3 flush, 4 drain.
  int m_phase = 0;
  int m_idx = 0;
  int m_cost [4];
  int m_x [4];
  int m_y [4];

  function automatic int model_cost(input int sad, input int mx, input int my);
    int c;
    c = sad;
`ifdef ME_MV_COST_EN
    c = sad + (((mx < 0 ? -mx : mx) + (my < 0 ? -my : my)) << 2);
    if (c > 65535) c = 65535;
`endif
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || frame_start) begin
      m_phase <= rst_n ? 1 : 0;
      m_idx   <= 0;
      for (int i = 0; i < 4; i++) begin
        m_cost[i] <= 65535;
        m_x[i]    <= 0;
        m_y[i]    <= 0;
      end
    end else begin
      case (m_phase)
        1: begin
          if (sad_valid) begin
            int mx, my, c;
            mx = int'(search_column_count) - 16;
            my = int'(search_row_count) - 32;
            c  = model_cost(int'(sad_value), mx, my);
            if (c < m_cost[sad_cb_id]) begin
              m_cost[sad_cb_id] <= c;
              m_x[sad_cb_id]    <= mx;
              m_y[sad_cb_id]    <= my;
            end
          end
          if (frame_done) m_phase <= 2;
        end
        2: m_phase <= 3;
        3: m_phase <= 4;
        4: if (out_ready) begin
          if (m_idx == 3) m_phase <= 0;
          else m_idx <= m_idx + 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("out_valid", 32'(out_valid), 32'(m_phase == 4));
    chk("out_last", 32'(out_last), 32'(m_phase == 4 && m_idx == 3));
    if (m_phase == 4) begin
      chk("out_cb_id", 32'(out_cb_id), 32'(m_idx));
      chk("out_cost", 32'(out_cost), 32'(m_cost[m_idx]));
      chk("out_mv_x", 32'($signed(out_mv_x)), 32'(m_x[m_idx]));
      chk("out_mv_y", 32'($signed(out_mv_y)), 32'(m_y[m_idx]));
    end else begin
      chk("idle_fields", {out_cost, out_mv_x, out_mv_y}, 32'd0);
    end
  end

  int rec_cost [4];
  int rec_x [4];
  int rec_y [4];

  task automatic sync;
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input logic junk);
    frame_start = 1'b1;
    sad_valid   = junk;
    sad_value   = 16'd0;
    sync();
    frame_start = 1'b0;
    sad_valid   = 1'b0;
  endtask

  task automatic send(input int cb, input int sad, input int row, input int col, input logic done);
    sad_valid           = 1'b1;
    sad_cb_id           = 2'(cb);
    sad_value           = 16'(sad);
    search_row_count    = 7'(row);
    search_column_count = 5'(col);
    frame_done          = done;
    sync();
    sad_valid  = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic end_frame;
    frame_done = 1'b1;
    sync();
    frame_done = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: hold CB2 for three cycles
  task automatic drain(input int mode, input int stop);
    int n, stall;
    logic [31:0] held;
    logic held_seen;
    n = 0; stall = 0; held_seen = 1'b0; held = '0;
    for (int i = 0; i < 4; i++) begin
      rec_cost[i] = -1; rec_x[i] = -999; rec_y[i] = -999;
    end
    for (int cyc = 0; cyc < 300 && n < stop; cyc++) begin
      if (mode == 2 && out_valid && out_cb_id == 2'd2 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else if (mode == 1) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (mode == 2 && out_valid && out_cb_id == 2'd2) begin
        if (held_seen) chk("cb2_held", {out_cost, out_mv_x, out_mv_y}, held);
        held      = {out_cost, out_mv_x, out_mv_y};
        held_seen = 1'b1;
      end
      if (out_valid) chk("last_only_cb3", 32'(out_last), 32'(out_cb_id == 2'd3));
      if (out_valid && out_ready) begin
        rec_cost[out_cb_id] = int'(out_cost);
        rec_x[out_cb_id]    = int'($signed(out_mv_x));
        rec_y[out_cb_id]    = int'($signed(out_mv_y));
        n++;
      end
      sync();
    end
    out_ready = 1'b0;
    if (n < stop) chk("drain_timeout", 32'(n), 32'(stop));
    if (mode == 2) chk("cb2_stall_cycles", 32'(stall), 32'd3);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    sync();
    rst_n = 1'b1;
    sync();

    // CB1 minimum with a tie that must keep the earlier candidate
    start_frame(1'b0);
    send(1, 100, 40, 20, 1'b0);
    send(1, 50, 10, 3, 1'b0);
    send(1, 50, 0, 0, 1'b0);
    end_frame();
    drain(0, 4);
`ifdef ME_MV_COST_EN
    chk("cb1_cost", 32'(rec_cost[1]), 32'd148);
    chk("cb1_mv_x", 32'(rec_x[1]), 32'd4);
    chk("cb1_mv_y", 32'(rec_y[1]), 32'd8);
`else
    chk("cb1_cost", 32'(rec_cost[1]), 32'd50);
    chk("cb1_mv_x", 32'(rec_x[1]), -32'sd13);
    chk("cb1_mv_y", 32'(rec_y[1]), -32'sd22);
`endif
    chk("cb0_untouched", 32'(rec_cost[0]), 32'd65535);

    // Stalled CB2 record and return to idle
    start_frame(1'b1);
    send(2, 300, 50, 25, 1'b0);
    send(3, 20, 33, 15, 1'b0);
    send(2, 299, 60, 5, 1'b1);
    drain(2, 4);
    @(negedge clk);
    chk("idle_after_drain", 32'(busy), 32'd0);
    sync();

    // frame_start after CB1 handshake aborts the drain and clears the table
    start_frame(1'b0);
    send(0, 5, 32, 16, 1'b0);
    send(1, 6, 32, 16, 1'b1);
    drain(0, 2);
    frame_start = 1'b1;
    sync();
    frame_start = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    sync();
    end_frame();
    drain(0, 4);
    for (int i = 0; i < 4; i++) chk("abort_cleared", 32'(rec_cost[i]), 32'd65535);

    // sample on frame_done counts; the one after is ignored
    start_frame(1'b0);
    send(0, 10, 32, 16, 1'b1);
    send(0, 5, 32, 16, 1'b0);
    drain(0, 4);
    chk("done_cycle_sample", 32'(rec_cost[0]), 32'd10);

    // Reset mid-drain, then untouched CBs report the cleared value
    start_frame(1'b0);
    send(0, 20, 32, 16, 1'b1);
    drain(0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {busy, out_valid, out_last, out_cb_id, out_mv_x, out_mv_y}, 32'd0);
    chk("rst_cost", 32'(out_cost), 32'd0);
    sync();
    rst_n = 1'b1;
    sync();
    start_frame(1'b0);
    send(2, 7, 33, 17, 1'b1);
    drain(0, 4);
    chk("post_rst_cb0_cost", 32'(rec_cost[0]), 32'd65535);
    chk("post_rst_cb0_mv", 32'(rec_x[0] | rec_y[0]), 32'd0);
    chk("post_rst_cb3_cost", 32'(rec_cost[3]), 32'd65535);

`ifdef ME_MV_COST_EN
    start_frame(1'b0);
    send(2, 100, 36, 13, 1'b0);
    send(3, 16'hFFF0, 127, 0, 1'b1);
    drain(0, 4);
    chk("mvcost_cb2", 32'(rec_cost[2]), 32'd128);
    chk("mvcost_cb2_x", 32'(rec_x[2]), -32'sd3);
    chk("mvcost_cb3_sat", 32'(rec_cost[3]), 32'd65535);
`endif

    // Randomized frames, including ignored inputs while idle
    for (int f = 0; f < 10; f++) begin
      frame_done = 1'b1;
      sad_valid  = 1'b1;
      sad_value  = 16'd1;
      sync();
      frame_done = 1'b0;
      sad_valid  = 1'b0;
      start_frame(1'($urandom_range(0, 1)));
      for (int s = $urandom_range(3, 30); s > 0; s--) begin
        if ($urandom_range(0, 3) != 0)
          send($urandom_range(0, 3),
               ($urandom_range(0, 7) == 0) ? 65535 : $urandom_range(0, 63),
               $urandom_range(0, 127), $urandom_range(0, 31), s == 1);
        else if (s == 1) end_frame();
        else sync();
      end
      drain(1, 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
